repetition_serial_encoder: RTL

Transmit side of the repetition error-control scheme: accepts one data word per upstream handshake and emits it REPETITION times on consecutive downstream beats over a DATA_WIDTH-wide channel. A receiver reassembles the beats into a REPETITION*DATA_WIDTH block, copy 0 in the least-significant bits, and feeds the block to the repetition checker. The block sits between a word producer and a narrow link, with valid/ready flow control on both sides.

---
 rtl/repetition_serial_encoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/repetition_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : repetition_serial_encoder
// Description : Transmit side of a repetition code. Accepts one word per
//               upstream handshake and replays it REPETITION times on
//               consecutive downstream beats, tagging each copy with its index.
// Revision    : 1.0 - initial release
// ============================================================================
module repetition_serial_encoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int REPETITION    = 3,
  localparam int COUNTER_WIDTH = (REPETITION > 1) ? $clog2(REPETITION) : 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     upstream_valid,
  output logic                     upstream_ready,
  input  logic [DATA_WIDTH-1:0]    upstream_data,
  output logic                     downstream_valid,
  input  logic                     downstream_ready,
  output logic [DATA_WIDTH-1:0]    downstream_data,
  output logic [COUNTER_WIDTH-1:0] downstream_index,
  output logic                     downstream_first,
  output logic                     downstream_last
);

  // Explicit terminal count: REPETITION need not be a power of two, so the
  // counter never relies on natural wrap-around.
  localparam logic [COUNTER_WIDTH-1:0] LAST_INDEX = COUNTER_WIDTH'(REPETITION - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE        = COUNTER_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SENDING = 1'b1
  } state_t;

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("repetition_serial_encoder: DATA_WIDTH must be >= 1");
  end
  if (REPETITION < 1) begin : g_bad_repetition
    $error("repetition_serial_encoder: REPETITION must be >= 1");
  end

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     first_q, first_d;
  logic                     last_q, last_d;
  logic                     upstream_handshake;
  logic                     downstream_handshake;

  // first/last are kept as flops (qualified by valid) so every downstream
  // output is registered; only upstream_ready is combinational.
  assign downstream_valid     = (state_q == SENDING);
  assign downstream_data      = word_q;
  assign downstream_index     = count_q;
  assign downstream_first     = first_q;
  assign downstream_last      = last_q;
  assign upstream_ready       = ~downstream_valid | (downstream_ready & last_q);
  assign upstream_handshake   = upstream_valid & upstream_ready;
  assign downstream_handshake = downstream_valid & downstream_ready;

  // State, held word, copy counter and beat tags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: load on upstream handshake, step copies on downstream
  // handshake, reload without a bubble when the last copy and a new word meet.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (upstream_handshake) begin
          state_d = SENDING;
          word_d  = upstream_data;
          count_d = '0;
        end
      end
      SENDING: begin
        if (downstream_handshake) begin
          if (count_q == LAST_INDEX) begin
            count_d = '0;
            if (upstream_handshake) begin
              word_d = upstream_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    first_d = (state_d == SENDING) && (count_d == '0);
    last_d  = (state_d == SENDING) && (count_d == LAST_INDEX);
  end

endmodule
`default_nettype wire
